// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter: IF/MEM requester ports plus the memory side.
// The arbiter uses the slave modport; the requester/memory model uses the master modport.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch and data ports,
// one access in flight, data priority with a starvation guard for fetch.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    unified_mem_arbiter_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for a request, arbitration happens here
    // ISSUE  | mem_en strobe for the latched access
    // WAIT   | counting memory latency, capture read data on the last cycle
    // RESP   | ack pulse to the owner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic              owner_d_q, owner_d_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              fetch_win;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_d_q  <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            starve_q   <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_d_q  <= owner_d_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d_d  = owner_d_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        fetch_win  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    fetch_win = bus.if_req && (!bus.d_req || (starve_q == STARVE_TOP));
                    if (fetch_win) begin
                        owner_d_d = 1'b0;
                        we_d      = 1'b0;
                        be_d      = 4'b0000;
                        addr_d    = bus.if_addr;
                        wdata_d   = '0;
                    end else begin
                        owner_d_d = 1'b1;
                        we_d      = bus.d_we;
                        be_d      = bus.d_we ? bus.d_be : 4'b0000;
                        addr_d    = bus.d_addr;
                        wdata_d   = bus.d_wdata;
                    end
                    // Only data grants that pass over a waiting fetch count toward starvation.
                    if (fetch_win || !bus.if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_TOP) begin
                        starve_d = starve_q + SW'(1);
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    if (!we_q) begin
                        if (owner_d_q) d_rdata_d  = bus.mem_rdata;
                        else           if_rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = (state_q == RESP) && !owner_d_q;
    assign bus.d_ack     = (state_q == RESP) && owner_d_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed plus randomized bench for unified_mem_arbiter against a transaction-level model.
module tb_unified_mem_arbiter;
    localparam int LAT  = 3;
    localparam int SMAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'h00208033;
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Memory device: driven only by the DUT's memory pins.
    logic [31:0] dev_mem [64];
    logic [31:0] pipe [LAT];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) dev_mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        pipe[0] <= (bus.mem_en && !bus.mem_we) ? dev_mem[bus.mem_addr[7:2]] : $urandom;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    // Reference model state
    logic [31:0] ref_mem [64];
    int          starve;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    logic [5:0]  obs_order;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of an IDLE cycle with at least one request held.
    // Returns at the negedge of the IDLE cycle following RESP.
    task automatic serve_one(input bit keep);
        logic fetch, we;
        logic [3:0] be;
        logic [31:0] addr, wdata;
        int idx;
        chk("idle_busy", 32'(bus.busy), 0);
        fetch = bus.if_req && (!bus.d_req || starve == SMAX);
        if (fetch || !bus.if_req) starve = 0;
        else if (starve < SMAX) starve++;
        we    = fetch ? 1'b0 : bus.d_we;
        be    = we ? bus.d_be : 4'b0000;
        addr  = fetch ? bus.if_addr : bus.d_addr;
        wdata = bus.d_wdata;
        idx   = int'(addr[7:2]);

        @(negedge clk);
        chk("issue_en",   32'(bus.mem_en), 1);
        chk("issue_addr", bus.mem_addr, addr);
        chk("issue_we",   32'(bus.mem_we), 32'(we));
        chk("issue_be",   32'(bus.mem_be), 32'(be));
        chk("issue_busy", 32'(bus.busy), 1);
        if (we) begin
            chk("issue_wdata", bus.mem_wdata, wdata);
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end

        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            chk("wait_en",   32'(bus.mem_en), 0);
            chk("wait_acks", 32'({bus.if_ack, bus.d_ack}), 0);
        end

        @(negedge clk);
        if (fetch) exp_if_rdata = ref_mem[idx];
        else if (!we) exp_d_rdata = ref_mem[idx];
        chk("resp_acks", 32'({bus.if_ack, bus.d_ack}), fetch ? 32'd2 : 32'd1);
        chk("if_rdata",  bus.if_rdata, exp_if_rdata);
        chk("d_rdata",   bus.d_rdata,  exp_d_rdata);
        obs_order = {obs_order[4:0], bus.if_ack};
        if (!keep) begin
            if (fetch) bus.if_req = 1'b0;
            else       bus.d_req  = 1'b0;
        end

        @(negedge clk);
        chk("post_acks", 32'({bus.if_ack, bus.d_ack}), 0);
        chk("post_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        starve = 0; exp_if_rdata = '0; exp_d_rdata = '0; obs_order = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_en",     32'(bus.mem_en), 0);
        chk("rst_we",     32'(bus.mem_we), 0);
        chk("rst_be",     32'(bus.mem_be), 0);
        chk("rst_addr",   bus.mem_addr, 0);
        chk("rst_wdata",  bus.mem_wdata, 0);
        chk("rst_acks",   32'({bus.if_ack, bus.d_ack}), 0);
        chk("rst_ifdata", bus.if_rdata, 0);
        chk("rst_ddata",  bus.d_rdata, 0);
        rst = 1'b0;

        // Single fetch of word at 0x8
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        serve_one(1'b0);
        chk("fetch8", bus.if_rdata, 32'h00208033);

        // Simultaneous fetch and load: data first
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4;
        serve_one(1'b0);
        serve_one(1'b0);
        chk("pair_order", 32'(obs_order[1:0]), 32'b01);

        // Store then fetch it back
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
        bus.d_addr = 32'hC; bus.d_wdata = 32'hDEADBEEF;
        serve_one(1'b0);
        bus.if_req = 1'b1; bus.if_addr = 32'hC;
        serve_one(1'b0);
        chk("store_fetch", bus.if_rdata, 32'hDEADBEEF);

        // Both held continuously: D,D,F,D,D,F
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        bus.if_req = 1'b1; bus.if_addr = 32'h24;
        for (int k = 0; k < 6; k++) serve_one(1'b1);
        chk("starve_order", 32'(obs_order), 32'b001001);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        @(negedge clk);
        chk("quiet_busy", 32'(bus.busy), 0);

        // Reset during WAIT aborts the load; held request is re-arbitrated
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h14;
        @(negedge clk);
        chk("abort_issue", 32'(bus.mem_en), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",  32'(bus.busy), 0);
        chk("abort_en",    32'(bus.mem_en), 0);
        chk("abort_acks",  32'({bus.if_ack, bus.d_ack}), 0);
        chk("abort_ddata", bus.d_rdata, 0);
        chk("abort_ifdat", bus.if_rdata, 0);
        starve = 0; exp_if_rdata = '0; exp_d_rdata = '0;
        rst = 1'b0;
        serve_one(1'b0);

        // Randomized traffic; losers keep holding their request
        for (int r = 0; r < 40; r++) begin
            if (!bus.if_req && ($urandom_range(0, 3) != 0)) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!bus.d_req && ($urandom_range(0, 3) != 0)) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_be    = 4'($urandom_range(1, 15));
                bus.d_addr  = 32'($urandom_range(0, 63)) << 2;
                bus.d_wdata = $urandom;
            end
            if (bus.if_req || bus.d_req) begin
                serve_one(1'b0);
            end else begin
                @(negedge clk);
                chk("rand_idle", 32'({bus.busy, bus.if_ack, bus.d_ack}), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
